assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/assoc_cache.sv | 193 +++++++++++++++++++
 tb/tb_assoc_cache.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache.sv
// Set-associative write-back cache with per-way LRU ages, write-allocate on miss and a
// one-set-per-cycle flush. A request is captured in IDLE, resolved in LOOKUP, answered in RESP.
module assoc_cache #(
  parameter int TAG_W  = 10,
  parameter int IDX_W  = 4,
  parameter int WAYS   = 4,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [TAG_W+IDX_W-1:0] req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   evict_valid,
  output logic [TAG_W+IDX_W-1:0] evict_addr,
  output logic [DATA_W-1:0]      evict_data
);

  localparam int SETS   = 2 ** IDX_W;
  localparam int ADDR_W = TAG_W + IDX_W;
  localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_W  = AGE_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  localparam logic [1:0] OP_FLUSH = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] flush_idx;

  logic [1:0]        op_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              hit_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic              evict_p1;
  logic [ADDR_W-1:0] evict_addr_p1;
  logic [DATA_W-1:0] evict_data_p1;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];

  // Accessed way drops to age 0; every way younger than it ages by one.
  function automatic logic [AGE_W-1:0] age_next(input logic [AGE_W-1:0] cur,
                                                input logic [AGE_W-1:0] acc_age,
                                                input logic             is_acc);
    if (is_acc)
      return '0;
    else if (cur < acc_age)
      return cur + 1'b1;
    else
      return cur;
  endfunction

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  assign idx = addr_p0[IDX_W-1:0];
  assign tag = addr_p0[ADDR_W-1:IDX_W];

  logic             hit;
  logic             has_invalid;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] old_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAY_W-1:0] acc_way;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    hit         = 1'b0;
    hit_way     = '0;
    has_invalid = 1'b0;
    inv_way     = '0;
    old_way     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        has_invalid = 1'b1;
        inv_way     = WAY_W'(w);
      end
      if (age_q[idx][w] == AGE_W'(WAYS - 1))
        old_way = WAY_W'(w);
    end
    victim_way = has_invalid ? inv_way : old_way;
    acc_way    = hit ? hit_way : victim_way;
  end

  logic accept;
  logic do_lookup;
  logic touch;
  logic wr_miss;
  assign accept    = (state == S_IDLE) && req_valid;
  assign do_lookup = (state == S_LOOKUP);
  assign touch     = do_lookup && (((op_p0 == OP_READ) && hit) || (op_p0 == OP_WRITE));
  assign wr_miss   = do_lookup && (op_p0 == OP_WRITE) && !hit;

  // Control state: FSM, valid/dirty bits and ages are the only reset targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      flush_idx <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      case (state)
        S_IDLE: begin
          flush_idx <= '0;
          if (req_valid)
            state <= (req_op == OP_FLUSH) ? S_FLUSH : S_LOOKUP;
        end
        S_LOOKUP: begin
          state <= S_RESP;
          if (touch) begin
            for (int w = 0; w < WAYS; w++)
              age_q[idx][w] <= age_next(age_q[idx][w], age_q[idx][acc_way],
                                        WAY_W'(w) == acc_way);
            if (op_p0 == OP_WRITE) begin
              valid_q[idx][acc_way] <= 1'b1;
              dirty_q[idx][acc_way] <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          valid_q[flush_idx] <= '0;
          dirty_q[flush_idx] <= '0;
          for (int w = 0; w < WAYS; w++)
            age_q[flush_idx][w] <= AGE_W'(w);
          flush_idx <= flush_idx + 1'b1;
          if (flush_idx == IDX_W'(SETS - 1))
            state <= S_RESP;
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: request capture; stage p1: lookup result held for the RESP cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0         <= req_op;
      addr_p0       <= req_addr;
      wdata_p0      <= req_wdata;
      hit_p1        <= 1'b0;
      rdata_p1      <= '0;
      evict_p1      <= 1'b0;
      evict_addr_p1 <= '0;
      evict_data_p1 <= '0;
    end
    if (do_lookup) begin
      hit_p1        <= ((op_p0 == OP_READ) || (op_p0 == OP_WRITE)) && hit;
      rdata_p1      <= ((op_p0 == OP_READ) && hit) ? data_q[idx][hit_way] : '0;
      evict_p1      <= wr_miss && valid_q[idx][victim_way] && dirty_q[idx][victim_way];
      evict_addr_p1 <= {tag_q[idx][victim_way], idx};
      evict_data_p1 <= data_q[idx][victim_way];
      if (op_p0 == OP_WRITE) begin
        data_q[idx][acc_way] <= wdata_p0;
        if (!hit)
          tag_q[idx][acc_way] <= tag;
      end
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign resp_valid  = (state == S_RESP);
  assign resp_hit    = resp_valid && hit_p1;
  assign resp_rdata  = resp_valid ? rdata_p1 : '0;
  assign evict_valid = resp_valid && evict_p1;
  assign evict_addr  = evict_valid ? evict_addr_p1 : '0;
  assign evict_data  = evict_valid ? evict_data_p1 : '0;

endmodule

// File: tb/tb_assoc_cache.sv
// Randomized bench for assoc_cache: an LRU-list cache model predicts every response cycle,
// with directed scenarios pinning latencies, hits and evictions to hand-computed values.
module tb_assoc_cache;

  localparam int TAG_W  = 10;
  localparam int IDX_W  = 4;
  localparam int WAYS   = 4;
  localparam int DATA_W = 16;
  localparam int SETS   = 16;
  localparam int ADDR_W = TAG_W + IDX_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'd3;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_rdata;
  logic              evict_valid;
  logic [ADDR_W-1:0] evict_addr;
  logic [DATA_W-1:0] evict_data;

  assoc_cache #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WAYS(WAYS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
    .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    bit                hit;
    logic [DATA_W-1:0] rdata;
    bit                ev;
    logic [ADDR_W-1:0] ev_addr;
    logic [DATA_W-1:0] ev_data;
  } exp_t;

  int checks = 0;
  int failures = 0;

  // Model: recency list per set (front = most recently used).
  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  int                m_tag   [SETS][WAYS];
  logic [DATA_W-1:0] m_data  [SETS][WAYS];
  int                rec     [SETS][$];
  exp_t              exp_q[$];
  exp_t              m_last;
  int                cyc = 0;
  int                ready_at = 0;
  int                m_acc_cyc = 0;
  int                m_prev_acc = 0;

  // DUT observations
  int                dut_resp_cyc = 0;
  int                dut_resp_count = 0;
  int                dut_ready_rise = 0;
  bit                prev_ready = 1'b1;
  bit                dut_hit;
  logic [DATA_W-1:0] dut_rdata;
  bit                dut_ev;
  logic [ADDR_W-1:0] dut_ev_addr;
  logic [DATA_W-1:0] dut_ev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void touch(int s, int w);
    for (int i = 0; i < rec[s].size(); i++)
      if (rec[s][i] == w) begin
        rec[s].delete(i);
        break;
      end
    rec[s].push_front(w);
  endfunction

  function automatic void clear_all();
    for (int s = 0; s < SETS; s++) begin
      rec[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        rec[s].push_back(w);
      end
    end
  endfunction

  task automatic accept(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, input int c0);
    exp_t e;
    int s, t, hw, v;
    s = int'(a) % SETS;
    t = int'(a) / SETS;
    e.hit = 0; e.rdata = '0; e.ev = 0; e.ev_addr = '0; e.ev_data = '0;
    m_prev_acc = m_acc_cyc;
    m_acc_cyc  = c0;
    if (op == 2'd0) begin
      clear_all();
      e.cyc    = c0 + SETS + 1;
      ready_at = c0 + SETS + 2;
    end else begin
      e.cyc    = c0 + 2;
      ready_at = c0 + 3;
      hw = -1;
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
      if (op == 2'd1 && hw >= 0) begin
        e.hit = 1; e.rdata = m_data[s][hw];
        touch(s, hw);
      end else if (op == 2'd2) begin
        if (hw >= 0) begin
          e.hit = 1;
          m_data[s][hw] = wd; m_dirty[s][hw] = 1'b1;
          touch(s, hw);
        end else begin
          v = -1;
          for (int w = WAYS - 1; w >= 0; w--)
            if (!m_valid[s][w]) v = w;
          if (v < 0) v = rec[s][rec[s].size() - 1];
          if (m_valid[s][v] && m_dirty[s][v]) begin
            e.ev = 1;
            e.ev_addr = ADDR_W'(m_tag[s][v] * SETS + s);
            e.ev_data = m_data[s][v];
          end
          m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b1;
          m_tag[s][v] = t; m_data[s][v] = wd;
          touch(s, v);
        end
      end
    end
    exp_q.push_back(e);
    m_last = e;
  endtask

  // Model advance at each active edge.
  initial begin
    clear_all();
    forever begin
      @(posedge clk);
      if (rst) begin
        clear_all();
        exp_q.delete();
        ready_at = 0;
      end else if (req_valid && cyc >= ready_at) begin
        accept(req_op, req_addr, req_wdata, cyc);
      end
      cyc++;
    end
  end

  // Compare process, 1 time unit after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("req_ready", req_ready, (cyc >= ready_at));
      if (req_ready && !prev_ready) dut_ready_rise = cyc;
      prev_ready = req_ready;
      if (resp_valid) begin
        dut_resp_cyc = cyc; dut_resp_count++;
        dut_hit = resp_hit; dut_rdata = resp_rdata;
        dut_ev = evict_valid; dut_ev_addr = evict_addr; dut_ev_data = evict_data;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("resp_valid", resp_valid, 1'b1);
        chk("resp_hit", resp_hit, e.hit);
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("evict_valid", evict_valid, e.ev);
        if (e.ev) begin
          chk("evict_addr", evict_addr, e.ev_addr);
          chk("evict_data", evict_data, e.ev_data);
        end
      end else begin
        chk("quiet_outputs", {resp_valid, resp_hit, resp_rdata, evict_valid, evict_addr, evict_data}, '0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n = 0;
    while (cyc < ready_at && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cyc < ready_at) begin
      checks++; failures++;
      $display("FAIL wait_idle: still busy at cycle %0d, required idle by %0d", cyc, ready_at);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    wait_idle();
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'd3;
    wait_idle();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  int r0;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_outputs", {resp_valid, resp_hit, resp_rdata, evict_valid, evict_addr, evict_data}, '0);
    do_reset(3);

    // Cold read miss, 2-cycle response latency
    issue(2'd1, 14'h012, 16'h0);
    chk("rd012_latency", dut_resp_cyc - m_acc_cyc, 2);
    chk("rd012_ready_back", dut_ready_rise - m_acc_cyc, 3);
    chk("rd012_hit", dut_hit, 1'b0);
    chk("rd012_rdata", dut_rdata, 16'h0);
    chk("rd012_evict", dut_ev, 1'b0);
    chk("model_rd012_hit", m_last.hit, 1'b0);

    // Write-allocate then read back; other tag in same set misses
    issue(2'd2, 14'h012, 16'hBEEF);
    chk("wr012_hit", dut_hit, 1'b0);
    issue(2'd1, 14'h012, 16'h0);
    chk("rd012b_hit", dut_hit, 1'b1);
    chk("rd012b_rdata", dut_rdata, 16'hBEEF);
    chk("model_rd012b_rdata", m_last.rdata, 16'hBEEF);
    issue(2'd1, 14'h022, 16'h0);
    chk("rd022_hit", dut_hit, 1'b0);

    // Fill set 5, refresh tag 1, allocate tag 5 -> LRU way (tag 2) evicted dirty
    for (int t = 1; t <= 4; t++) issue(2'd2, ADDR_W'(t * 16 + 5), DATA_W'(t * 16'h1111));
    issue(2'd1, 14'h015, 16'h0);
    chk("rd015_rdata", dut_rdata, 16'h1111);
    issue(2'd2, 14'h055, 16'h5555);
    chk("wr055_evict", dut_ev, 1'b1);
    chk("wr055_evict_addr", dut_ev_addr, 14'h025);
    chk("wr055_evict_data", dut_ev_data, 16'h2222);
    chk("model_wr055_evict_addr", m_last.ev_addr, 14'h025);
    issue(2'd1, 14'h015, 16'h0);
    chk("rd015b_hit", dut_hit, 1'b1);

    // Flush discards dirty data without eviction
    issue(2'd2, 14'h0A3, 16'hA3A3);
    issue(2'd0, 14'h0A3, 16'h0);
    chk("flush_resp_latency", dut_resp_cyc - m_acc_cyc, 17);
    chk("flush_ready_back", dut_ready_rise - m_acc_cyc, 18);
    chk("flush_hit", dut_hit, 1'b0);
    issue(2'd1, 14'h0A3, 16'h0);
    chk("rd0A3_hit", dut_hit, 1'b0);
    chk("rd0A3_evict", dut_ev, 1'b0);

    // Reset during FLUSH cycle 7
    issue(2'd2, 14'h04C, 16'h1234);
    wait_idle();
    r0 = dut_resp_count;
    req_valid = 1'b1; req_op = 2'd0;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'd3;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_flush_ready", req_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_flush_noresp", dut_resp_count - r0, 0);
    issue(2'd1, 14'h04C, 16'h0);
    chk("rd04C_hit", dut_hit, 1'b0);

    // Reset during LOOKUP of a write
    issue(2'd2, 14'h07D, 16'h7777);
    wait_idle();
    r0 = dut_resp_count;
    req_valid = 1'b1; req_op = 2'd2; req_addr = 14'h08D; req_wdata = 16'h8888;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'd3;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_lookup_ready", req_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_lookup_noresp", dut_resp_count - r0, 0);
    issue(2'd1, 14'h07D, 16'h0);
    chk("rd07D_hit", dut_hit, 1'b0);
    issue(2'd1, 14'h08D, 16'h0);
    chk("rd08D_hit", dut_hit, 1'b0);

    // Held req_valid with changing op while busy: only IDLE-cycle requests execute
    wait_idle();
    req_valid = 1'b1; req_op = 2'd2; req_addr = 14'h0B4; req_wdata = 16'h5A5A;
    @(negedge clk);
    req_op = 2'd0; req_addr = 14'h0C4;
    @(negedge clk);
    req_op = 2'd2; req_addr = 14'h0C4; req_wdata = 16'hDEAD;
    @(negedge clk);
    req_op = 2'd1; req_addr = 14'h0B4;
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'd3;
    wait_idle();
    chk("held_accept_spacing", m_acc_cyc - m_prev_acc, 3);
    chk("held_rd_hit", dut_hit, 1'b1);
    chk("held_rd_rdata", dut_rdata, 16'h5A5A);
    issue(2'd1, 14'h0C4, 16'h0);
    chk("held_junk_miss", dut_hit, 1'b0);

    // Randomized traffic: small tag/set space for hits, evictions and LRU churn
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst = (i >= 1500 && i < 1502);
      r = $urandom_range(0, 99);
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = (r < 2) ? 2'd0 : (r < 45) ? 2'd1 : (r < 90) ? 2'd2 : 2'd3;
      req_addr  = ADDR_W'($urandom_range(0, 5) * 16 + $urandom_range(0, 3));
      req_wdata = DATA_W'($urandom);
      @(negedge clk);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
